// File: rtl/frog_ctrl_if.sv
// rtl/frog_ctrl_if.sv - frog_ctrl video-timing, controller and game-status signal bundle
`timescale 1ns/1ps

interface frog_ctrl_if;
  logic        frame_tick;
  logic [9:0]  colPos;
  logic [9:0]  rowPos;
  logic [5:0]  pix_color;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic [3:0]  frog_col;
  logic [3:0]  frog_row;
  logic        frog_pix;
  logic        bg_on;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [7:0]  score;
  logic [10:0] time_left;

  modport master (
    output frame_tick, colPos, rowPos, pix_color,
    output btn_up, btn_down, btn_left, btn_right, btn_start,
    input  frog_col, frog_row, frog_pix, bg_on, state, lives, score, time_left
  );

  modport slave (
    input  frame_tick, colPos, rowPos, pix_color,
    input  btn_up, btn_down, btn_left, btn_right, btn_start,
    output frog_col, frog_row, frog_pix, bg_on, state, lives, score, time_left
  );
endinterface

// File: rtl/frog_ctrl.sv
// rtl/frog_ctrl.sv - Frogger game sequencer: frog position, game FSM, lives, score
// Optional life timer enabled by defining FROG_TIMER_EN.
`timescale 1ns/1ps

module frog_ctrl #(
  parameter int         X_OFFSET_LEFT = 96,
  parameter int         BLOCKSIZE     = 32,
  parameter int         LIVES         = 3,
  parameter int         DEATH_FRAMES  = 60,
  parameter int         WIN_FRAMES    = 30,
  parameter int         TIME_FRAMES   = 1800,
  parameter logic [5:0] HAZARD_WATER  = 6'b000011,
  parameter logic [5:0] HAZARD_CAR    = 6'b110000
) (
  input  logic       clk,
  input  logic       rst_n,
  frog_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DEATH = 3'd2,
    S_WIN   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

`ifdef FROG_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  localparam int CNT_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t      state_q;
  logic [3:0]  col_q, row_q;
  logic [1:0]  lives_q;
  logic [7:0]  score_q;
  logic [10:0] time_left;
  logic [CW-1:0] cnt_q;
  logic [5:0]  sample_q;
  logic [4:0]  btn_q, pend, btn_now, rise;

  logic [10:0] tile_x, tile_y, col11, row11;
  logic        strobe, in_tile;
  logic [3:0]  mv_col, mv_row;
  logic        hazard, timeout, death_done, win_done, enter_play;

  // bit order: up, down, left, right, start
  assign btn_now = {bus.btn_start, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign rise    = btn_now & ~btn_q;

  assign tile_x = 11'(X_OFFSET_LEFT) + 11'(col_q) * 11'(BLOCKSIZE);
  assign tile_y = 11'(row_q) * 11'(BLOCKSIZE);
  assign col11  = {1'b0, bus.colPos};
  assign row11  = {1'b0, bus.rowPos};

  assign strobe  = (col11 == tile_x + 11'(BLOCKSIZE / 2)) &&
                   (row11 == tile_y + 11'(BLOCKSIZE / 2));
  assign in_tile = (col11 >= tile_x) && (col11 <= tile_x + 11'(BLOCKSIZE - 1)) &&
                   (row11 >= tile_y) && (row11 <= tile_y + 11'(BLOCKSIZE - 1));

  // Highest-priority pending move is chosen first; a wall turns it into a no-op.
  always_comb begin
    mv_col = col_q;
    mv_row = row_q;
    if (pend[0]) begin
      if (row_q != 4'd0) mv_row = row_q - 4'd1;
    end else if (pend[1]) begin
      if (row_q != 4'd14) mv_row = row_q + 4'd1;
    end else if (pend[2]) begin
      if (col_q != 4'd0) mv_col = col_q - 4'd1;
    end else if (pend[3]) begin
      if (col_q != 4'd13) mv_col = col_q + 4'd1;
    end
  end

  assign hazard     = (sample_q == HAZARD_WATER) || (sample_q == HAZARD_CAR);
  assign timeout    = TIMER_ON && (time_left <= 11'd1);
  assign death_done = (state_q == S_DEATH) && (cnt_q == CW'(DEATH_FRAMES - 1));
  assign win_done   = (state_q == S_WIN) && (cnt_q == CW'(WIN_FRAMES - 1));
  assign enter_play = (((state_q == S_IDLE) || (state_q == S_OVER)) && pend[4]) ||
                      (death_done && (lives_q != 2'd1)) || win_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      col_q    <= 4'd7;
      row_q    <= 4'd14;
      lives_q  <= 2'(LIVES);
      score_q  <= 8'd0;
      cnt_q    <= '0;
      sample_q <= 6'b000000;
      btn_q    <= '0;
      pend     <= '0;
    end else begin
      btn_q <= btn_now;
      pend  <= bus.frame_tick ? 5'd0 : (pend | rise);
      // A strobe on the tick cycle keeps the fresh sample; evaluation below sees the old one.
      if (strobe)              sample_q <= bus.pix_color;
      else if (bus.frame_tick) sample_q <= 6'b000000;

      if (bus.frame_tick) begin
        case (state_q)
          S_IDLE, S_OVER: begin
            if (pend[4]) begin
              state_q <= S_PLAY;
              lives_q <= 2'(LIVES);
              score_q <= 8'd0;
              col_q   <= 4'd7;
              row_q   <= 4'd14;
              cnt_q   <= '0;
            end
          end
          S_PLAY: begin
            if (hazard || timeout) begin
              state_q <= S_DEATH;
              cnt_q   <= '0;
            end else begin
              col_q <= mv_col;
              row_q <= mv_row;
              if (mv_row == 4'd0) begin
                state_q <= S_WIN;
                score_q <= score_q + 8'd1;
                cnt_q   <= '0;
              end
            end
          end
          S_DEATH: begin
            if (death_done) begin
              cnt_q   <= '0;
              lives_q <= lives_q - 2'd1;
              if (lives_q == 2'd1) begin
                state_q <= S_OVER;
              end else begin
                state_q <= S_PLAY;
                col_q   <= 4'd7;
                row_q   <= 4'd14;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WIN: begin
            if (win_done) begin
              cnt_q   <= '0;
              state_q <= S_PLAY;
              col_q   <= 4'd7;
              row_q   <= 4'd14;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_left <= 11'd0;
    end else if (TIMER_ON && bus.frame_tick) begin
      if (state_q == S_PLAY)
        time_left <= (time_left != 11'd0) ? time_left - 11'd1 : 11'd0;
      else if (enter_play)
        time_left <= 11'(TIME_FRAMES);
    end
  end

  assign bus.frog_col  = col_q;
  assign bus.frog_row  = row_q;
  assign bus.frog_pix  = in_tile && (state_q != S_IDLE) && (state_q != S_OVER);
  assign bus.bg_on     = (state_q != S_IDLE);
  assign bus.state     = state_q;
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.time_left = time_left;

endmodule

// File: doc/frog_ctrl.md
Name: frog_ctrl

Overview:
- Game sequencer for the Frogger playfield.
- Owns the frog position, the game state machine, lives and score, and the background enable.
- Each frame it samples the composited pixel colour under the frog centre and decides death or win at the frame tick.
- Sits between the VGA timing and controller inputs and the pixel compositor, and drives the background `on` input.

Parameters:
- X_OFFSET_LEFT, 96, left edge of the playfield in pixels.
- BLOCKSIZE, 32, tile size in pixels; frog is one tile.
- LIVES, 3, lives granted on game start.
- DEATH_FRAMES, 60, frames held in DEATH.
- WIN_FRAMES, 30, frames held in WIN.
- TIME_FRAMES, 1800, per-life time budget (optional feature).
- HAZARD_WATER, 6'b000011, colour meaning open water.
- HAZARD_CAR, 6'b110000, colour meaning vehicle.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blanking.
- colPos  in  10  current pixel column.
- rowPos  in  10  current pixel row.
- pix_color  in  6  composited colour at (colPos,rowPos), frog layer excluded.
- btn_up, btn_down, btn_left, btn_right, btn_start  in  1 each  synchronized, debounced levels.
- frog_col  out  4  tile column 0..13.
- frog_row  out  4  tile row 0..14; row 0 is the goal.
- frog_pix  out  1  current pixel lies inside the frog tile.
- bg_on  out  1  background enable.
- state  out  3  IDLE=0, PLAY=1, DEATH=2, WIN=3, OVER=4.
- lives  out  2  remaining lives.
- score  out  8  completed crossings.
- time_left  out  11  remaining frames of the life timer.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, frog_col=7, frog_row=14, lives=LIVES, score=0, time_left=0.
  - Sample register = 6'b000000; pending move flags cleared; frame counter=0.
- Button edge detect:
  - Each button is registered once; a rising edge sets its pending flag.
  - Holding a button gives exactly one move.
  - Pending flags clear on every frame_tick.
- Sampling:
  - Sample point: colPos == X_OFFSET_LEFT + frog_col*BLOCKSIZE + BLOCKSIZE/2 and rowPos == frog_row*BLOCKSIZE + BLOCKSIZE/2.
  - On that cycle, pix_color is latched into the sample register.
  - At frame_tick the register is evaluated, then reset to black.
  - If sample strobe and frame_tick coincide, evaluation uses the old value and the new sample is kept.
- frog_pix (combinational from registered position):
  - Column condition: colPos in [X_OFFSET_LEFT+frog_col*32, +31].
  - Row condition: rowPos in [frog_row*32, +31].
  - frog_pix=1 only when both hold.
  - Forced to 0 in IDLE and OVER.
- bg_on: 0 in IDLE, 1 in all other states.
- All state changes occur only on frame_tick cycles, except the asynchronous reset.
- IDLE / OVER:
  - btn_start rising edge → PLAY at the next frame_tick.
  - Entering PLAY sets lives=LIVES, score=0, frog=(7,14).
- PLAY, evaluated at frame_tick in this order:
  1. Sample equals HAZARD_WATER or HAZARD_CAR → DEATH; the pending move is discarded.
  2. Otherwise apply one move, priority up > down > left > right.
     - Up decrements the row; down increments it.
     - Left decrements the column; right increments it.
     - Clamp to column 0..13 and row 0..14; a move into a wall is a no-op.
  3. If the resulting row==0 → WIN, and score increments (wraps 255→0).
- DEATH:
  - The frame counter counts frame_ticks; after DEATH_FRAMES ticks, lives decrements.
  - If lives becomes 0 → OVER (frog stays put); else respawn at (7,14) → PLAY.
- WIN: after WIN_FRAMES ticks, respawn at (7,14) → PLAY; lives unchanged.
- The frame counter clears on every state change.
- btn_start is ignored outside IDLE/OVER.

Optional Feature:
- Macro FROG_TIMER_EN.
- Defined:
  - time_left loads TIME_FRAMES on each entry to PLAY from IDLE, OVER, DEATH or WIN.
  - time_left decrements on each PLAY frame_tick.
  - Reaching 0 in PLAY → DEATH, evaluated with the same priority as hazard (before the move).
  - time_left holds its value in other states.
- Not defined: time_left is tied to 0 and no timeout death exists.

Test Plan:
- Reset low mid-PLAY with frog at (3,5) → immediately state=0, frog=(7,14), lives=3, score=0, bg_on=0, frog_pix=0.
- IDLE, pulse btn_start, then frame_tick → state=1, lives=3. Hold btn_up for 5 frames → frog_row 14→13 only (one move per press).
- PLAY at (0,10), press left and up before one tick → row=9, col=0 (up wins). Then press left → col stays 0.
- Drive pix_color=6'b000011 at the sample point for frog (7,6), then frame_tick → DEATH. After 60 ticks → lives=2, frog=(7,14), PLAY. On the third such death → OVER, lives=0.
- Frog at (4,1) with safe sample, press up, then tick → row=0, state=3, score=1. After 30 ticks → PLAY at (7,14), lives unchanged.
- FROG_TIMER_EN with TIME_FRAMES=4, no hazards → after 4 PLAY ticks, time_left=0 and state=DEATH. Without the macro: 10 ticks later still PLAY, time_left=0.
